// File: rtl/adder_csa_pipe.sv
// rtl/adder_csa_pipe.sv - two-stage carry-select add/sub with valid/ready handshake
// Stage 1 builds per-block candidate sums; stage 2 ripples block carries to pick them.
module adder_csa_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLK;

  logic             adv;
  logic             take;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [BLK:0]     t0;
  logic [BLK:0]     t1;

  logic                      v1_d, v1_q;
  logic [NBLK-1:0][BLK-1:0]  s0_d, s0_q, s1_d, s1_q;
  logic [NBLK-1:0]           co0_d, co0_q, co1_d, co1_q;
  logic                      cm0_d, cm0_q, cm1_d, cm1_q;

  logic             v2_d, v2_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  logic [WIDTH-1:0] sel_sum;
  logic             sel_c;
  logic             sel_cm;

  assign adv      = !v2_q || out_ready;
  assign take     = adv && in_valid;
  assign in_ready = adv;

  // Block 0 already knows its carry-in, so both of its candidates use c0 and
  // stage 2 can treat every block uniformly.
  always_comb begin
    b_eff = sub ? ~b : b;
    c0    = sub ? ~cin : cin;
    t0    = '0;
    t1    = '0;
    v1_d  = adv ? in_valid : v1_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    co0_d = co0_q;
    co1_d = co1_q;
    cm0_d = cm0_q;
    cm1_d = cm1_q;
    if (take) begin
      for (int k = 0; k < NBLK; k++) begin
        t0 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]}
           + {{BLK{1'b0}}, ((k == 0) ? c0 : 1'b0)};
        t1 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]}
           + {{BLK{1'b0}}, ((k == 0) ? c0 : 1'b1)};
        s0_d[k]  = t0[BLK-1:0];
        s1_d[k]  = t1[BLK-1:0];
        co0_d[k] = t0[BLK];
        co1_d[k] = t1[BLK];
      end
      // Carry into the MSB recovered from the top block's sum bit.
      cm0_d = t0[BLK-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
      cm1_d = t1[BLK-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
    end
  end

  always_comb begin
    sel_c   = 1'b0;
    sel_cm  = 1'b0;
    sel_sum = '0;
    for (int k = 0; k < NBLK; k++) begin
      sel_sum[k*BLK +: BLK] = sel_c ? s1_q[k] : s0_q[k];
      if (k == NBLK - 1) begin
        sel_cm = sel_c ? cm1_q : cm0_q;
      end
      sel_c = sel_c ? co1_q[k] : co0_q[k];
    end
  end

  always_comb begin
    v2_d   = adv ? v1_q : v2_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (adv && v1_q) begin
      sum_d  = sel_sum;
      cout_d = sel_c;
      ovf_d  = sel_cm ^ sel_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      s0_q   <= '0;
      s1_q   <= '0;
      co0_q  <= '0;
      co1_q  <= '0;
      cm0_q  <= 1'b0;
      cm1_q  <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      co0_q  <= co0_d;
      co1_q  <= co1_d;
      cm0_q  <= cm0_d;
      cm1_q  <= cm1_d;
      v2_q   <= v2_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_csa_pipe.sv
// tb/tb_adder_csa_pipe.sv - bench for adder_csa_pipe at 16/4, 32/8 and 8/8
module tb_adder_csa_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin, sub;
  logic [31:0] a32, b32;

  logic        rdy16, ov16, co16, of16;
  logic [15:0] s16;
  logic        rdy32, ov32, co32, of32;
  logic [31:0] s32;
  logic        rdy8, ov8, co8, of8;
  logic [7:0]  s8;

  always #5 clk = ~clk;

  adder_csa_pipe #(.WIDTH(16), .BLK(4)) d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
    .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16));

  adder_csa_pipe #(.WIDTH(32), .BLK(8)) d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .a(a32), .b(b32), .cin(cin), .sub(sub),
    .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .ovf(of32));

  adder_csa_pipe #(.WIDTH(8), .BLK(8)) d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .a(a32[7:0]), .b(b32[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8));

  logic        obs_v[3];
  logic        obs_rdy[3];
  logic [33:0] obs_r[3];

  assign obs_v[0] = ov16;
  assign obs_v[1] = ov32;
  assign obs_v[2] = ov8;
  assign obs_rdy[0] = rdy16;
  assign obs_rdy[1] = rdy32;
  assign obs_rdy[2] = rdy8;
  assign obs_r[0] = {of16, co16, 16'h0, s16};
  assign obs_r[1] = {of32, co32, s32};
  assign obs_r[2] = {of8, co8, 24'h0, s8};

  int          wid[3] = '{16, 32, 8};
  bit          m1_v[3], m2_v[3];
  logic [33:0] m1_r[3], m2_r[3];
  int          exp_n[3], obs_n[3];
  int          total = 0;
  int          bad   = 0;

  // Reference: plain integer arithmetic, overflow from operand/result signs.
  function automatic logic [33:0] model_res(int w, logic [31:0] av_in, logic [31:0] bv_in,
                                            bit ci, bit sb);
    longint mask, av, bv, s, sm;
    bit     sa, sbb, ss, co, ov;
    mask = (longint'(1) << w) - 1;
    av   = longint'(av_in) & mask;
    bv   = (sb ? longint'(~bv_in) : longint'(bv_in)) & mask;
    s    = av + bv + (sb ? longint'(!ci) : longint'(ci));
    sm   = s & mask;
    co   = ((s >> w) & 1) != 0;
    sa   = ((av >> (w - 1)) & 1) != 0;
    sbb  = ((bv >> (w - 1)) & 1) != 0;
    ss   = ((sm >> (w - 1)) & 1) != 0;
    ov   = (sa == sbb) && (ss != sa);
    return {ov, co, sm[31:0]};
  endfunction

  task automatic chk(string tag, logic [33:0] obs, logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("in_ready[%0d]", i), obs_rdy[i], !m2_v[i] || out_ready);
      if (obs_v[i] && out_ready) obs_n[i]++;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (m2_v[i] && out_ready) exp_n[i]++;
      if (rst) begin
        m1_v[i] = 0;
        m2_v[i] = 0;
      end else if (!m2_v[i] || out_ready) begin
        m2_v[i] = m1_v[i];
        m2_r[i] = m1_r[i];
        m1_v[i] = in_valid;
        m1_r[i] = model_res(wid[i], a32, b32, cin, sub);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid[%0d]", i), obs_v[i], m2_v[i]);
      if (m2_v[i]) chk($sformatf("result[%0d]", i), obs_r[i], m2_r[i]);
    end
  endtask

  task automatic op(logic [31:0] av, logic [31:0] bv, logic ci, logic sb);
    a32 = av; b32 = bv; cin = ci; sub = sb; in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    a32 = '0; b32 = '0;
    for (int i = 0; i < 3; i++) begin
      m1_v[i] = 0; m2_v[i] = 0; m1_r[i] = '0; m2_r[i] = '0; exp_n[i] = 0; obs_n[i] = 0;
    end
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_state", {ov16, of16, co16, s16}, 19'h0);
    chk("rst_in_ready", rdy16, 1'b1);

    op(32'hFFFF, 32'h0001, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("add_wrap", {ov16, of16, co16, s16}, {1'b1, 1'b0, 1'b1, 16'h0000});

    op(32'h8000, 32'h0001, 1'b0, 1'b1);
    cycle();
    op(32'h0000, 32'h0001, 1'b0, 1'b1);
    cycle();
    chk("sub_ovf", {of16, co16, s16}, {1'b1, 1'b1, 16'h7FFF});
    in_valid = 1'b0;
    cycle();
    chk("sub_neg", {of16, co16, s16}, {1'b0, 1'b0, 16'hFFFF});

    op(32'h7FFF, 32'h0000, 1'b1, 1'b0);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("add_cin_ovf", {of16, co16, s16}, {1'b1, 1'b0, 16'h8000});
    cycle();

    out_ready = 1'b0;
    op(32'd1, 32'd2, 1'b0, 1'b0);
    cycle();
    op(32'd10, 32'd20, 1'b0, 1'b0);
    cycle();
    op(32'd100, 32'd200, 1'b0, 1'b0);
    cycle();
    chk("stall_in_ready", rdy16, 1'b0);
    chk("stall_first", {ov16, s16}, {1'b1, 16'd3});
    cycle();
    chk("stall_hold", {ov16, of16, co16, s16}, {1'b1, 1'b0, 1'b0, 16'd3});
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("order_second", {ov16, s16}, {1'b1, 16'd30});
    cycle();
    chk("order_third", {ov16, s16}, {1'b1, 16'd300});
    cycle();
    chk("order_drained", ov16, 1'b0);

    op(32'd5, 32'd6, 1'b0, 1'b0);
    cycle();
    op(32'd7, 32'd8, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid0", ov16, 1'b0);
    chk("flush_in_ready", rdy16, 1'b1);
    cycle();
    chk("flush_valid1", ov16, 1'b0);
    cycle();
    chk("flush_valid2", ov16, 1'b0);

    for (int n = 0; n < 12000; n++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      a32 = $urandom;
      b32 = $urandom;
      case ($urandom_range(0, 7))
        0: a32 = 32'hFFFF_FFFF;
        1: b32 = 32'hFFFF_FFFF;
        2: a32 = 32'h8080_8080;
        3: b32 = 32'h0;
        default: ;
      endcase
      cycle();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) cycle();
    for (int i = 0; i < 3; i++) chk($sformatf("transfer_count[%0d]", i), obs_n[i], exp_n[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
